// File: rtl/boot_sequencer_if.sv
// Bus bundle for boot_sequencer: boot ROM read port, CPU memory port, RAM port
// and CPU run control, plus a debug view of the sequencer state.
//
// Handshakes: ROM reads are single-cycle (rom_data is valid in the same cycle
// as rom_rd). CPU and RAM cycles are request/ack: the requester holds rd or wr
// with stable addr/wdata until the cycle in which ack is high, and ack may be
// high in the very first cycle a request is presented. rdata is valid with ack.
interface boot_sequencer_if;
    logic        boot_req;
    logic [14:0] rom_addr;
    logic        rom_rd;
    logic [11:0] rom_data;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_ack;
    logic [11:0] cpu_rdata;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic [11:0] mem_rdata;
    logic        cpu_halt;
    logic        cpu_start;
    logic [14:0] cpu_start_pc;
    logic        done;
    logic [1:0]  dbg_state;

    modport master (
        input  boot_req, rom_data, cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
               mem_ack, mem_rdata,
        output rom_addr, rom_rd, cpu_ack, cpu_rdata, mem_addr, mem_wdata,
               mem_rd, mem_wr, cpu_halt, cpu_start, cpu_start_pc, done,
               dbg_state
    );

    modport slave (
        output boot_req, rom_data, cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
               mem_ack, mem_rdata,
        input  rom_addr, rom_rd, cpu_ack, cpu_rdata, mem_addr, mem_wdata,
               mem_rd, mem_wr, cpu_halt, cpu_start, cpu_start_pc, done,
               dbg_state
    );
endinterface

// File: rtl/boot_sequencer.sv
// Bootstrap controller: copies LEN words from boot ROM into RAM while the CPU
// is halted, starts the CPU at START_PC, then passes CPU cycles through to RAM.
module boot_sequencer #(
    parameter logic [14:0] SRC_BASE = 15'o07416,
    parameter logic [14:0] DST_BASE = 15'o07750,
    parameter logic [7:0]  LEN      = 8'd5,
    parameter logic [14:0] START_PC = 15'o07750
) (
    input logic              clk,
    input logic              reset,
    boot_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        START = 2'd2,
        DONE  = 2'd3
    } state_t;

    // An empty copy skips straight to releasing the CPU.
    localparam state_t     FIRST = (LEN == 8'd0) ? START : LOAD;
    localparam logic [7:0] LAST  = LEN - 8'd1;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [11:0] wbuf;
    logic        pend;
    logic        honour;
    logic        rd_q;
    logic        wr_q;
    logic        halt_q;
    logic        start_q;
    logic        done_q;

    // A latched re-boot waits for an idle CPU so no CPU cycle is cut short.
    assign honour = pend && !bus.cpu_rd && !bus.cpu_wr;

    always_comb begin
        state_nxt = state;
        if (reset) begin
            state_nxt = FIRST;
        end else begin
            case (state)
                LOAD:    state_nxt = WRITE;
                WRITE:   if (bus.mem_ack) state_nxt = (cnt == LAST) ? START : LOAD;
                START:   state_nxt = DONE;
                default: if (honour) state_nxt = FIRST;
            endcase
        end
    end

    // Output flags are registered from the next state so they are clean
    // decodes of the state actually entered.
    always_ff @(posedge clk) begin
        state   <= state_nxt;
        rd_q    <= (state_nxt == LOAD);
        wr_q    <= (state_nxt == WRITE);
        halt_q  <= (state_nxt == LOAD) || (state_nxt == WRITE);
        start_q <= (state_nxt == START);
        done_q  <= (state_nxt == DONE);
        if (reset) begin
            cnt  <= 8'd0;
            pend <= 1'b0;
        end else begin
            case (state)
                LOAD:  wbuf <= bus.rom_data;
                WRITE: if (bus.mem_ack && cnt != LAST) cnt <= cnt + 8'd1;
                START: ;
                default: begin
                    if (honour) begin
                        pend <= 1'b0;
                        cnt  <= 8'd0;
                    end else if (bus.boot_req) begin
                        pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Reset masks every request immediately, dropping any RAM write in flight.
    assign bus.rom_rd       = rd_q & ~reset;
    assign bus.rom_addr     = SRC_BASE + {7'd0, cnt};
    assign bus.mem_addr     = done_q ? bus.cpu_addr : (DST_BASE + {7'd0, cnt});
    assign bus.mem_wdata    = done_q ? bus.cpu_wdata : wbuf;
    assign bus.mem_wr       = (done_q ? bus.cpu_wr : wr_q) & ~reset;
    assign bus.mem_rd       = done_q & bus.cpu_rd & ~reset;
    assign bus.cpu_ack      = done_q & bus.mem_ack & ~reset;
    assign bus.cpu_rdata    = bus.mem_rdata;
    assign bus.cpu_halt     = halt_q | reset;
    assign bus.cpu_start    = start_q & ~reset;
    assign bus.cpu_start_pc = START_PC;
    assign bus.done         = done_q & ~reset;
    assign bus.dbg_state    = state;

endmodule
